// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - shared encodings and defaults for the HI/LO multiply/divide unit
package md_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multiply/divide unit holding HI/LO with fixed-latency busy window
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hilo_out
);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        divz_q, divz_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] divisor;
  logic signed [31:0] quot_s, rem_s;
  logic        [31:0] quot_u, rem_u;

  // Divisor forced to 1 on zero so the arithmetic stays defined; the result is discarded anyway.
  assign divisor = (rt_val == 32'd0) ? 32'd1 : rt_val;
  assign prod_s  = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u  = {32'd0, rs_val} * {32'd0, rt_val};
  assign quot_s  = $signed(rs_val) / $signed(divisor);
  assign rem_s   = $signed(rs_val) % $signed(divisor);
  assign quot_u  = rs_val / divisor;
  assign rem_u   = rs_val % divisor;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      divz_q   <= divz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    divz_d   = divz_q;
    case (state_q)
      ST_IDLE: begin
        // A start pulse always swallows a same-cycle mthi/mtlo strobe.
        if (start) begin
          case (md_op)
            MD_MULT: begin
              res_hi_d = prod_s[63:32];
              res_lo_d = prod_s[31:0];
              divz_d   = 1'b0;
              cnt_d    = 4'(MULT_CYCLES);
              state_d  = ST_RUN;
            end
            MD_MULTU: begin
              res_hi_d = prod_u[63:32];
              res_lo_d = prod_u[31:0];
              divz_d   = 1'b0;
              cnt_d    = 4'(MULT_CYCLES);
              state_d  = ST_RUN;
            end
            MD_DIV: begin
              res_hi_d = rem_s;
              res_lo_d = quot_s;
              divz_d   = (rt_val == 32'd0);
              cnt_d    = 4'(DIV_CYCLES);
              state_d  = ST_RUN;
            end
            MD_DIVU: begin
              res_hi_d = rem_u;
              res_lo_d = quot_u;
              divz_d   = (rt_val == 32'd0);
              cnt_d    = 4'(DIV_CYCLES);
              state_d  = ST_RUN;
            end
            default: ;
          endcase
        end else if (hilo_we) begin
          if (hilo_sel) hi_d = rs_val;
          else          lo_d = rs_val;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (!divz_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q == ST_RUN);
  assign stall_req = start | busy;
  assign hilo_out  = hilo_sel ? hi_q : lo_q;

endmodule
